// File: rtl/dmux_stream_nway.sv
// Registered N-way stream demultiplexer with a valid/ready handshake.
// Each input word goes to one channel (in_sel) or to every channel (in_bcast).
// Every channel has its own one-entry output register, so a stalled sink
// blocks only words aimed at that channel.
module dmux_stream_nway #(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_bcast,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic                sel_err,
    output logic [15:0]         xfer_cnt
);

    logic [N-1:0]        valid_q, valid_d;
    logic [N*DATA_W-1:0] data_q, data_d;
    logic                sel_err_q, sel_err_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [N-1:0]        free;
    logic [N-1:0]        sel_hit;
    logic [N-1:0]        load;
    logic                sel_ok;
    logic                accept;

    // Channel availability, selection decode and input-side handshake.
    // Selecting through a one-hot decode keeps out-of-range in_sel values
    // from indexing past the last channel.
    always_comb begin
        free    = ~valid_q | out_ready;
        sel_hit = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
        sel_ok = |sel_hit;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = |(sel_hit & free);
        end else begin
            in_ready = 1'b1;
        end
        accept = in_valid & in_ready;
        load   = '0;
        if (accept) begin
            load = in_bcast ? '1 : sel_hit;
        end
    end

    // Next state: drains clear valid flags, loads set them and win over a
    // same-cycle drain; lane data changes only when that lane is loaded.
    always_comb begin
        valid_d = (valid_q & ~out_ready) | load;
        data_d  = data_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (load[k]) begin
                data_d[k*DATA_W +: DATA_W] = in_data;
            end
        end
        sel_err_d = accept & ~in_bcast & ~sel_ok;
        cnt_d     = accept ? cnt_q + 16'd1 : cnt_q;
    end

    // State registers with synchronous reset that overrides any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        out_valid = valid_q;
        out_data  = data_q;
        sel_err   = sel_err_q;
        xfer_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_dmux_stream_nway.sv
// Self-checking bench for dmux_stream_nway: an 8-channel instance checked
// every cycle against a queue/array model, plus a 6-channel instance for the
// out-of-range select case, with literal checks on the directed scenarios.
module tb_dmux_stream_nway;

    logic         clk = 1'b0;
    logic         reset;

    // 8-channel DUT
    logic         in_valid, in_ready, in_bcast;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic [7:0]   out_valid, out_ready;
    logic [127:0] out_data;
    logic         sel_err;
    logic [15:0]  xfer_cnt;

    // 6-channel DUT
    logic         v6, rdy6, b6;
    logic [15:0]  d6;
    logic [2:0]   s6;
    logic [5:0]   ov6, or6;
    logic [95:0]  od6;
    logic         err6;
    logic [15:0]  cnt6;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model of the 8-channel instance
    bit   [7:0]  mv;
    logic [15:0] md [8];
    bit          merr;
    int unsigned mcnt;
    logic [15:0] sb [8][$];

    always #5 clk = ~clk;

    dmux_stream_nway #(.DATA_W(16), .N(8), .SEL_W(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    dmux_stream_nway #(.DATA_W(16), .N(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(reset), .in_valid(v6), .in_ready(rdy6),
        .in_data(d6), .in_sel(s6), .in_bcast(b6),
        .out_valid(ov6), .out_ready(or6), .out_data(od6),
        .sel_err(err6), .xfer_cnt(cnt6)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input may be taken when every targeted channel is empty or being drained.
    function automatic bit model_ready();
        bit [7:0] fr;
        fr = ~mv | out_ready;
        if (in_bcast) return &fr;
        if (int'(in_sel) < 8) return fr[in_sel];
        return 1'b1;
    endfunction

    // Model update on each clock edge from the inputs presented to it.
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            mv   = '0;
            merr = 1'b0;
            mcnt = 0;
            for (int k = 0; k < 8; k++) begin
                md[k] = '0;
                sb[k].delete();
            end
        end else begin
            acc  = in_valid && model_ready();
            merr = 1'b0;
            for (int k = 0; k < 8; k++)
                if (mv[k] && out_ready[k]) mv[k] = 1'b0;
            if (acc) begin
                mcnt = (mcnt + 1) % 65536;
                for (int k = 0; k < 8; k++) begin
                    if (in_bcast || (int'(in_sel) == k)) begin
                        mv[k] = 1'b1;
                        md[k] = in_data;
                        sb[k].push_back(in_data);
                    end
                end
                if (!in_bcast && int'(in_sel) >= 8) merr = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the 8-channel DUT against the model, and
    // scoreboard pop for every word the sink takes.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [127:0] exp_data;
            for (int k = 0; k < 8; k++) exp_data[k*16 +: 16] = md[k];
            check("in_ready", {127'b0, in_ready}, {127'b0, model_ready()});
            check("out_valid", {120'b0, out_valid}, {120'b0, mv});
            check("out_data", out_data, exp_data);
            check("sel_err", {127'b0, sel_err}, {127'b0, merr});
            check("xfer_cnt", {112'b0, xfer_cnt}, 128'(mcnt));
            for (int k = 0; k < 8; k++) begin
                if (mv[k] && out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        check("sb_underflow", 128'(k), 128'hFFFF);
                    end else begin
                        logic [15:0] w;
                        w = sb[k].pop_front();
                        check("sb_word", {112'b0, out_data[k*16 +: 16]}, {112'b0, w});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_bcast = 0; in_data = '0; in_sel = '0; out_ready = '1;
        v6 = 0; b6 = 0; d6 = '0; s6 = '0; or6 = '1;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", {120'b0, out_valid}, 128'h0);
        check("rst_data", out_data, 128'h0);
        check("rst_cnt", {112'b0, xfer_cnt}, 128'h0);
        check("rst_err", {127'b0, sel_err}, 128'h0);

        // T1: single unicast word to channel 5
        in_valid = 1; in_sel = 3'd5; in_data = 16'h1234;
        step();
        in_valid = 0;
        check("t1_valid", {120'b0, out_valid}, 128'h20);
        check("t1_lane5", {112'b0, out_data[80 +: 16]}, 128'h1234);
        check("t1_cnt", {112'b0, xfer_cnt}, 128'd1);

        // T2: back-pressure on channel 2, then no-bubble refill
        out_ready = 8'hFB;
        in_valid = 1; in_sel = 3'd2; in_data = 16'hAAAA;
        #1 check("t2_rdy1", {127'b0, in_ready}, 128'd1);
        step();
        in_data = 16'hBBBB;
        #1 check("t2_rdy2", {127'b0, in_ready}, 128'd0);
        check("t2_hold_a", {112'b0, out_data[32 +: 16]}, 128'hAAAA);
        step();
        check("t2_still_a", {112'b0, out_data[32 +: 16]}, 128'hAAAA);
        check("t2_v2", {127'b0, out_valid[2]}, 128'd1);
        out_ready = 8'hFF;
        #1 check("t2_rdy3", {127'b0, in_ready}, 128'd1);
        step();
        in_valid = 0;
        check("t2_lane_b", {112'b0, out_data[32 +: 16]}, 128'hBBBB);
        check("t2_v2b", {127'b0, out_valid[2]}, 128'd1);
        check("t2_cnt", {112'b0, xfer_cnt}, 128'd3);

        // T3: broadcast blocked by a full, stalled channel 7
        out_ready = 8'h7F;
        in_valid = 1; in_sel = 3'd7; in_data = 16'h7777;
        step();
        in_bcast = 1; in_data = 16'h00FF;
        #1 check("t3_rdy0", {127'b0, in_ready}, 128'd0);
        step();
        check("t3_v80", {120'b0, out_valid}, 128'h80);
        out_ready = 8'hFF;
        #1 check("t3_rdy1", {127'b0, in_ready}, 128'd1);
        step();
        in_valid = 0; in_bcast = 0;
        check("t3_vff", {120'b0, out_valid}, 128'hFF);
        check("t3_data", out_data, {8{16'h00FF}});
        check("t3_cnt", {112'b0, xfer_cnt}, 128'd5);
        step();

        // T4: out-of-range select on the 6-channel instance
        or6 = 6'b111101;
        v6 = 1; s6 = 3'd1; d6 = 16'h1111;
        step();
        s6 = 3'd7; d6 = 16'hDEAD;
        #1 check("t4_rdy", {127'b0, rdy6}, 128'd1);
        step();
        v6 = 0;
        check("t4_err", {127'b0, err6}, 128'd1);
        check("t4_valid", {122'b0, ov6}, 128'h02);
        check("t4_cnt", {112'b0, cnt6}, 128'd2);
        check("t4_lane1", {112'b0, od6[16 +: 16]}, 128'h1111);
        step();
        check("t4_err_off", {127'b0, err6}, 128'd0);

        // Mixed traffic: rotating back-pressure, occasional broadcast and gaps
        for (int i = 0; i < 200; i++) begin
            logic [7:0] pat;
            pat = 8'b1011_0110;
            out_ready = (pat << (i % 8)) | (pat >> (8 - (i % 8)));
            in_valid = (i % 5) != 4;
            in_bcast = (i % 7) == 3;
            in_sel = 3'(i * 3);
            in_data = 16'hC000 + 16'(i);
            step();
        end
        in_valid = 0; in_bcast = 0; out_ready = '1;
        step(); step();

        // T5: long rotating stream, counter wrap
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1;
            in_sel = 3'(i);
            in_data = 16'(i * 7 + 3);
            step();
        end
        in_valid = 0;
        check("t5_cnt", {112'b0, xfer_cnt}, 128'd4464);
        check("t5_model_cnt", 128'(mcnt), 128'd4464);
        step(); step();
        for (int k = 0; k < 8; k++)
            check("t5_sb_empty", 128'(sb[k].size()), 128'd0);

        // T6: reset while ch3 is full and a word for ch1 is accepted
        out_ready = 8'hF7;
        in_valid = 1; in_sel = 3'd3; in_data = 16'h3333;
        step();
        in_sel = 3'd1; in_data = 16'h1010;
        v6 = 1; s6 = 3'd7;
        reset = 1;
        step();
        reset = 0; in_valid = 0; v6 = 0;
        check("t6_valid", {120'b0, out_valid}, 128'h0);
        check("t6_data", out_data, 128'h0);
        check("t6_cnt", {112'b0, xfer_cnt}, 128'h0);
        check("t6_err", {127'b0, sel_err}, 128'h0);
        check("t6_err6", {127'b0, err6}, 128'h0);
        check("t6_cnt6", {112'b0, cnt6}, 128'h0);
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
